// File: rtl/fifoc2cs.sv
// fifoc2cs: drains one command frame from fifoc per fs/fd handshake, validates
// length, header and (optionally) checksum, then commits the nine command bytes.
// Optional feature macro: CMD_CHECKSUM_EN (byte 11 must match the payload sum).
module fifoc2cs #(
  parameter logic [7:0]  HEAD0     = 8'h55,
  parameter logic [7:0]  HEAD1     = 8'hAA,
  parameter int unsigned FRAME_LEN = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fs,
  output logic        fd,
  input  logic [11:0] data_len,
  output logic        fifoc_rxen,
  input  logic [7:0]  fifoc_rxd,
  output logic [7:0]  cmd_kdev,
  output logic [7:0]  cmd_smpr,
  output logic [7:0]  cmd_filt,
  output logic [7:0]  cmd_mix0,
  output logic [7:0]  cmd_mix1,
  output logic [7:0]  cmd_reg4,
  output logic [7:0]  cmd_reg5,
  output logic [7:0]  cmd_reg6,
  output logic [7:0]  cmd_reg7,
  output logic        cmd_update,
  output logic        err_fifoc2cs
);

  localparam int unsigned LW   = 12;
  localparam int unsigned DW   = 8;
  localparam int unsigned NCMD = 9;

  typedef enum logic [2:0] {S_IDLE, S_READ, S_LAST, S_CHECK, S_DONE} state_e;

  state_e          state_q, state_d;
  logic [LW-1:0]   len_q, len_d;
  logic [LW-1:0]   rd_cnt_q, rd_cnt_d;
  logic [LW-1:0]   idx_q, idx_d;
  logic            rd_valid_q, rd_valid_d;
  logic            hdr_ok_q, hdr_ok_d;
  logic [DW-1:0]   shadow_q [NCMD];
  logic [DW-1:0]   shadow_d [NCMD];
  logic [DW-1:0]   cmd_q [NCMD];
  logic [DW-1:0]   cmd_d [NCMD];
  logic            fd_q, fd_d;
  logic            rxen_q, rxen_d;
  logic            upd_q, upd_d;
  logic            err_q, err_d;
  logic            csum_ok_c;
  logic            frame_ok_c;
`ifdef CMD_CHECKSUM_EN
  logic [DW-1:0]   csum_q, csum_d;
  logic [DW-1:0]   rx_csum_q, rx_csum_d;
`endif

  // Byte capture, frame checks and handshake FSM next-state logic.
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    rd_cnt_d   = rd_cnt_q;
    idx_d      = idx_q;
    rd_valid_d = rxen_q;
    hdr_ok_d   = hdr_ok_q;
    shadow_d   = shadow_q;
    cmd_d      = cmd_q;
    upd_d      = 1'b0;
    err_d      = err_q;
`ifdef CMD_CHECKSUM_EN
    csum_d     = csum_q;
    rx_csum_d  = rx_csum_q;
    csum_ok_c  = (rx_csum_q == csum_q);
`else
    csum_ok_c  = 1'b1;
`endif
    frame_ok_c = (len_q == LW'(FRAME_LEN)) && hdr_ok_q && csum_ok_c;

    // fifoc data is valid the cycle after an rxen cycle; bytes past 11 are drained only.
    if (rd_valid_q) begin
      idx_d = idx_q + LW'(1);
      if (idx_q == LW'(0)) begin
        hdr_ok_d = (fifoc_rxd == HEAD0);
      end else if (idx_q == LW'(1)) begin
        hdr_ok_d = hdr_ok_q && (fifoc_rxd == HEAD1);
      end
      for (int i = 0; i < int'(NCMD); i++) begin
        if (idx_q == LW'(i + 2)) begin
          shadow_d[i] = fifoc_rxd;
        end
      end
`ifdef CMD_CHECKSUM_EN
      if ((idx_q >= LW'(2)) && (idx_q <= LW'(10))) begin
        csum_d = csum_q + fifoc_rxd;
      end
      if (idx_q == LW'(11)) begin
        rx_csum_d = fifoc_rxd;
      end
`endif
    end

    case (state_q)
      S_IDLE: begin
        if (fs) begin
          len_d    = data_len;
          rd_cnt_d = '0;
          idx_d    = '0;
          hdr_ok_d = 1'b0;
          err_d    = 1'b0;
`ifdef CMD_CHECKSUM_EN
          csum_d   = '0;
`endif
          state_d  = (data_len == LW'(0)) ? S_CHECK : S_READ;
        end
      end
      S_READ: begin
        rd_cnt_d = rd_cnt_q + LW'(1);
        if (rd_cnt_q == len_q - LW'(1)) begin
          state_d = S_LAST;
        end
      end
      S_LAST: begin
        state_d = S_CHECK;
      end
      S_CHECK: begin
        if (frame_ok_c) begin
          cmd_d = shadow_q;
          upd_d = 1'b1;
        end else begin
          err_d = 1'b1;
        end
        state_d = S_DONE;
      end
      S_DONE: begin
        if (!fs) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    rxen_d = (state_d == S_READ);
    fd_d   = (state_d == S_DONE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      len_q      <= '0;
      rd_cnt_q   <= '0;
      idx_q      <= '0;
      rd_valid_q <= 1'b0;
      hdr_ok_q   <= 1'b0;
      shadow_q   <= '{default: '0};
      cmd_q      <= '{default: '0};
      fd_q       <= 1'b0;
      rxen_q     <= 1'b0;
      upd_q      <= 1'b0;
      err_q      <= 1'b0;
`ifdef CMD_CHECKSUM_EN
      csum_q     <= '0;
      rx_csum_q  <= '0;
`endif
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      rd_cnt_q   <= rd_cnt_d;
      idx_q      <= idx_d;
      rd_valid_q <= rd_valid_d;
      hdr_ok_q   <= hdr_ok_d;
      shadow_q   <= shadow_d;
      cmd_q      <= cmd_d;
      fd_q       <= fd_d;
      rxen_q     <= rxen_d;
      upd_q      <= upd_d;
      err_q      <= err_d;
`ifdef CMD_CHECKSUM_EN
      csum_q     <= csum_d;
      rx_csum_q  <= rx_csum_d;
`endif
    end
  end

  assign fd           = fd_q;
  assign fifoc_rxen   = rxen_q;
  assign cmd_update   = upd_q;
  assign err_fifoc2cs = err_q;
  assign cmd_kdev     = cmd_q[0];
  assign cmd_smpr     = cmd_q[1];
  assign cmd_filt     = cmd_q[2];
  assign cmd_mix0     = cmd_q[3];
  assign cmd_mix1     = cmd_q[4];
  assign cmd_reg4     = cmd_q[5];
  assign cmd_reg5     = cmd_q[6];
  assign cmd_reg6     = cmd_q[7];
  assign cmd_reg7     = cmd_q[8];

endmodule

// File: tb/tb_fifoc2cs.sv
// Bench for fifoc2cs: directed frame table, reset abort, then random frames
// checked against a frame-level reference model.
module tb_fifoc2cs;

  logic        clk = 1'b0;
  logic        rst;
  logic        fs;
  logic        fd;
  logic [11:0] data_len;
  logic        fifoc_rxen;
  logic [7:0]  fifoc_rxd = 8'h00;
  logic [7:0]  cmd_kdev, cmd_smpr, cmd_filt, cmd_mix0, cmd_mix1;
  logic [7:0]  cmd_reg4, cmd_reg5, cmd_reg6, cmd_reg7;
  logic        cmd_update;
  logic        err_fifoc2cs;

  fifoc2cs dut (
    .clk          (clk),
    .rst          (rst),
    .fs           (fs),
    .fd           (fd),
    .data_len     (data_len),
    .fifoc_rxen   (fifoc_rxen),
    .fifoc_rxd    (fifoc_rxd),
    .cmd_kdev     (cmd_kdev),
    .cmd_smpr     (cmd_smpr),
    .cmd_filt     (cmd_filt),
    .cmd_mix0     (cmd_mix0),
    .cmd_mix1     (cmd_mix1),
    .cmd_reg4     (cmd_reg4),
    .cmd_reg5     (cmd_reg5),
    .cmd_reg6     (cmd_reg6),
    .cmd_reg7     (cmd_reg7),
    .cmd_update   (cmd_update),
    .err_fifoc2cs (err_fifoc2cs)
  );

  always #5 clk = ~clk;

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] fifo_q  [$];
  logic [7:0] frame_q [$];
  logic [7:0] model_cmd [9];
  int         rxen_cnt = 0;
  int         upd_cnt  = 0;

  // fifoc model: read data appears the cycle after rxen.
  always @(posedge clk) begin
    if (fifoc_rxen && fifo_q.size() > 0) fifoc_rxd <= fifo_q.pop_front();
  end

  // Count read-enable and update cycles per frame.
  always @(negedge clk) begin
    if (fifoc_rxen) rxen_cnt++;
    if (cmd_update) upd_cnt++;
  end

  typedef struct {
    int         len;
    logic [7:0] h0;
    logic [7:0] h1;
    logic [7:0] base;
    logic [7:0] cdelta;
    int         hold;
    bit         exp_err;
  } vec_t;

  task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [71:0] dut_cmd();
    return {cmd_kdev, cmd_smpr, cmd_filt, cmd_mix0, cmd_mix1,
            cmd_reg4, cmd_reg5, cmd_reg6, cmd_reg7};
  endfunction

  function automatic logic [71:0] mdl_cmd();
    logic [71:0] v = '0;
    for (int i = 0; i < 9; i++) v = {v[63:0], model_cmd[i]};
    return v;
  endfunction

  // Build a frame: header, 9 payload bytes, checksum (+cdelta), then trim/pad to len.
  task automatic build(input int len, input logic [7:0] h0, input logic [7:0] h1,
                       input logic [7:0] base, input bit rnd, input logic [7:0] cdelta);
    int s = 0;
    logic [7:0] b;
    frame_q.delete();
    frame_q.push_back(h0);
    frame_q.push_back(h1);
    for (int i = 0; i < 9; i++) begin
      b = rnd ? 8'($urandom) : 8'(base + 8'(i));
      s += int'(b);
      frame_q.push_back(b);
    end
    frame_q.push_back(8'(s % 256) + cdelta);
    while (frame_q.size() > len) void'(frame_q.pop_back());
    while (frame_q.size() < len) frame_q.push_back(8'hA5);
  endtask

  // Reference rule: exact length, both header bytes, and checksum when enabled.
  function automatic bit rule_ok(input int len);
    int s = 0;
    if (len != 12) return 1'b0;
    if (frame_q[0] != 8'h55 || frame_q[1] != 8'hAA) return 1'b0;
`ifdef CMD_CHECKSUM_EN
    for (int i = 2; i <= 10; i++) s += int'(frame_q[i]);
    if (frame_q[11] != 8'(s % 256)) return 1'b0;
`endif
    return 1'b1;
  endfunction

  task automatic run_frame(input int len, input int hold, input bit exp_err, input string nm);
    int cyc = 0;
    int exp_lat = (len == 0) ? 2 : len + 3;
    if (!exp_err) for (int i = 0; i < 9; i++) model_cmd[i] = frame_q[i + 2];
    foreach (frame_q[i]) fifo_q.push_back(frame_q[i]);
    rxen_cnt = 0;
    upd_cnt  = 0;
    data_len = 12'(len);
    fs       = 1'b1;
    while (fd !== 1'b1 && cyc < 6000) begin
      @(negedge clk);
      cyc++;
    end
    chk({nm, " latency"}, 72'(cyc), 72'(exp_lat));
    chk({nm, " err"}, 72'(err_fifoc2cs), 72'(exp_err));
    chk({nm, " cmd"}, dut_cmd(), mdl_cmd());
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk({nm, " fd hold"}, 72'(fd), 72'(1));
    end
    fs = 1'b0;
    @(negedge clk);
    chk({nm, " fd drop"}, 72'(fd), 72'(0));
    chk({nm, " rxen count"}, 72'(rxen_cnt), 72'(len));
    chk({nm, " update count"}, 72'(upd_cnt), 72'(!exp_err));
    chk({nm, " fifo drained"}, 72'(fifo_q.size()), 72'(0));
    chk({nm, " err held"}, 72'(err_fifoc2cs), 72'(exp_err));
  endtask

  initial begin
    vec_t vecs [10];
    bit   csum_bad_err;
`ifdef CMD_CHECKSUM_EN
    csum_bad_err = 1'b1;
`else
    csum_bad_err = 1'b0;
`endif
    vecs[0] = '{12, 8'h55, 8'hAA, 8'h01, 8'h00, 0,  1'b0};
    vecs[1] = '{12, 8'h55, 8'hAA, 8'h01, 8'h01, 0,  csum_bad_err};
    vecs[2] = '{12, 8'h55, 8'hAB, 8'h21, 8'h00, 0,  1'b1};
    vecs[3] = '{12, 8'h55, 8'hAA, 8'h31, 8'h00, 0,  1'b0};
    vecs[4] = '{20, 8'h55, 8'hAA, 8'h41, 8'h00, 0,  1'b1};
    vecs[5] = '{12, 8'h55, 8'hAA, 8'h51, 8'h00, 0,  1'b0};
    vecs[6] = '{0,  8'h55, 8'hAA, 8'h00, 8'h00, 0,  1'b1};
    vecs[7] = '{11, 8'h55, 8'hAA, 8'h71, 8'h00, 0,  1'b1};
    vecs[8] = '{12, 8'h55, 8'hAA, 8'h61, 8'h00, 10, 1'b0};
    vecs[9] = '{12, 8'h55, 8'hAA, 8'hF0, 8'h00, 2,  1'b0};
    for (int i = 0; i < 9; i++) model_cmd[i] = 8'h00;

    rst      = 1'b1;
    fs       = 1'b0;
    data_len = 12'd0;
    repeat (3) @(negedge clk);
    chk("reset fd", 72'(fd), 72'(0));
    chk("reset rxen", 72'(fifoc_rxen), 72'(0));
    chk("reset update", 72'(cmd_update), 72'(0));
    chk("reset err", 72'(err_fifoc2cs), 72'(0));
    chk("reset cmd", dut_cmd(), 72'(0));
    rst = 1'b0;
    @(negedge clk);

    for (int v = 0; v < 10; v++) begin
      build(vecs[v].len, vecs[v].h0, vecs[v].h1, vecs[v].base, 1'b0, vecs[v].cdelta);
      run_frame(vecs[v].len, vecs[v].hold, vecs[v].exp_err, $sformatf("vec%0d", v));
    end

    // Reset while rd_cnt==5 aborts the frame and clears committed commands.
    build(12, 8'h55, 8'hAA, 8'h81, 1'b0, 8'h00);
    foreach (frame_q[i]) fifo_q.push_back(frame_q[i]);
    data_len = 12'd12;
    fs       = 1'b1;
    repeat (6) @(negedge clk);
    chk("mid-frame rxen", 72'(fifoc_rxen), 72'(1));
    rst = 1'b1;
    @(negedge clk);
    chk("abort rxen", 72'(fifoc_rxen), 72'(0));
    chk("abort fd", 72'(fd), 72'(0));
    chk("abort cmd", dut_cmd(), 72'(0));
    chk("abort err", 72'(err_fifoc2cs), 72'(0));
    fs  = 1'b0;
    rst = 1'b0;
    fifo_q.delete();
    for (int i = 0; i < 9; i++) model_cmd[i] = 8'h00;
    @(negedge clk);
    build(12, 8'h55, 8'hAA, 8'h91, 1'b0, 8'h00);
    run_frame(12, 0, 1'b0, "post-reset");

    // Random frames against the rule model.
    for (int r = 0; r < 25; r++) begin
      int         len;
      logic [7:0] h0, h1, cd;
      len = ($urandom_range(0, 9) < 3) ? int'($urandom_range(0, 20)) : 12;
      h0  = ($urandom_range(0, 9) < 8) ? 8'h55 : 8'($urandom);
      h1  = ($urandom_range(0, 9) < 8) ? 8'hAA : 8'($urandom);
      cd  = ($urandom_range(0, 9) < 7) ? 8'h00 : 8'($urandom_range(1, 255));
      build(len, h0, h1, 8'h00, 1'b1, cd);
      run_frame(len, int'($urandom_range(0, 3)), !rule_ok(len), $sformatf("rnd%0d", r));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
